// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction-fetch stage. Owns the PC, fetches words over a
//               req/ack handshake, buffers a word across hazard stalls, and
//               drains abandoned requests after a redirect. Presents an
//               all-zero bubble to IF/ID when no instruction is available.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] PC_4_out,
  output logic        fetch_busy
);

  // REQ  : request outstanding at pc
  // HOLD : word fetched for pc, waiting for IF/ID to accept it
  // DRAIN: finishing a request abandoned by a redirect (response dropped)
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] buf_instr_q;
  logic [31:0] drain_addr_q;

  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_avail;
  logic [31:0] w_instr;

  // Redirect targets are word aligned; the low bits are simply cleared.
  assign w_target   = redirect_target & 32'hFFFF_FFFC;
  assign w_pc_plus4 = pc_q + 32'd4;

  // An instruction is available on a fresh ack in REQ or from the buffer in
  // HOLD, but never on a redirect cycle (IF/ID is being flushed then).
  always_comb begin
    w_avail = 1'b0;
    w_instr = 32'h0;
    if (!reset && !redirect) begin
      if (state_q == ST_REQ && imem_ack) begin
        w_avail = 1'b1;
        w_instr = imem_rdata;
      end else if (state_q == ST_HOLD) begin
        w_avail = 1'b1;
        w_instr = buf_instr_q;
      end
    end
  end

  // Output drive: all-zero bubble while in reset or with nothing to present.
  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = 32'h0;
    instr_out  = 32'h0;
    PC_4_out   = 32'h0;
    fetch_busy = 1'b1;
    if (!reset) begin
      case (state_q)
        ST_REQ: begin
          imem_req  = 1'b1;
          imem_addr = pc_q;
        end
        ST_DRAIN: begin
          imem_req  = 1'b1;
          imem_addr = drain_addr_q;
        end
        default: begin
          imem_req  = 1'b0;
          imem_addr = pc_q;
        end
      endcase
      if (w_avail) begin
        instr_out  = w_instr;
        PC_4_out   = w_pc_plus4;
        fetch_busy = 1'b0;
      end
    end
  end

  // Fetch FSM with PC, stall buffer and drain-address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      buf_instr_q  <= 32'h0;
      drain_addr_q <= 32'h0;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (redirect) begin
            pc_q <= w_target;
            if (!imem_ack) begin
              // Request still open: keep its address stable until it acks.
              drain_addr_q <= pc_q;
              state_q      <= ST_DRAIN;
            end
          end else if (imem_ack && !stall) begin
            pc_q <= w_pc_plus4;
          end else if (imem_ack) begin
            buf_instr_q <= imem_rdata;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            pc_q        <= w_target;
            buf_instr_q <= 32'h0;
            state_q     <= ST_REQ;
          end else if (!stall) begin
            pc_q    <= w_pc_plus4;
            state_q <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (redirect) begin
            pc_q <= w_target;
          end
          if (imem_ack) begin
            state_q <= ST_REQ;
          end
        end
        default: begin
          state_q <= ST_REQ;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] PC_4_out;
  logic        fetch_busy;

  int n_chk;
  int n_fail;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_out       (instr_out),
    .PC_4_out        (PC_4_out),
    .fetch_busy      (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF; redirect = 1'b1; redirect_target = 32'h44;
    #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", imem_req); end
    n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h exp 0", imem_addr); end
    n_chk++; if (instr_out !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h exp 0", instr_out); end
    n_chk++; if (PC_4_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc4: got %h exp 0", PC_4_out); end
    n_chk++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b exp 1", fetch_busy); end
    reset = 1'b0; imem_ack = 1'b0; redirect = 1'b0;
    #1;
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_first_req: got %b exp 1", imem_req); end
    n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_first_addr: got %h exp 0", imem_addr); end
    next_cycle();
  endtask

  // Ack every cycle: addresses 0,4,8,C and PC+4 values 4,8,C,10.
  task automatic test_zero_wait();
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 4);
      imem_ack = 1'b1; imem_rdata = a | 32'h2000_0000;
      #1;
      n_chk++; if (imem_addr !== a) begin n_fail++; $display("FAIL zw_addr[%0d]: got %h exp %h", i, imem_addr, a); end
      n_chk++; if (PC_4_out !== a + 32'd4) begin n_fail++; $display("FAIL zw_pc4[%0d]: got %h exp %h", i, PC_4_out, a + 32'd4); end
      n_chk++; if (instr_out !== (a | 32'h2000_0000)) begin n_fail++; $display("FAIL zw_instr[%0d]: got %h exp %h", i, instr_out, a | 32'h2000_0000); end
      n_chk++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL zw_busy[%0d]: got %b exp 0", i, fetch_busy); end
      next_cycle();
    end
    imem_ack = 1'b0;
  endtask

  // pc=0x10: ack while stalled, then three stalled HOLD cycles, then release.
  task automatic test_stall_at_ack();
    stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
    #1;
    n_chk++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL st_addr: got %h exp 10", imem_addr); end
    n_chk++; if (instr_out !== 32'h8C22_0004) begin n_fail++; $display("FAIL st_ack_instr: got %h exp 8c220004", instr_out); end
    next_cycle();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL st_hold_req[%0d]: got %b exp 0", i, imem_req); end
      n_chk++; if (instr_out !== 32'h8C22_0004) begin n_fail++; $display("FAIL st_hold_instr[%0d]: got %h exp 8c220004", i, instr_out); end
      n_chk++; if (PC_4_out !== 32'h14) begin n_fail++; $display("FAIL st_hold_pc4[%0d]: got %h exp 14", i, PC_4_out); end
      next_cycle();
    end
    stall = 1'b0;
    #1;
    n_chk++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL st_rel_busy: got %b exp 0", fetch_busy); end
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL st_rel_req: got %b exp 0", imem_req); end
    next_cycle();
    #1;
    n_chk++; if (imem_addr !== 32'h14) begin n_fail++; $display("FAIL st_next_addr: got %h exp 14", imem_addr); end
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL st_next_req: got %b exp 1", imem_req); end
    n_chk++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL st_next_busy: got %b exp 1", fetch_busy); end
  endtask

  // Ack one cycle after each request, at 0x14 and 0x18.
  task automatic test_latency2();
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      a = 32'h14 + 32'(i * 4);
      imem_ack = 1'b0;
      #1;
      n_chk++; if (imem_addr !== a) begin n_fail++; $display("FAIL l2_wait_addr[%0d]: got %h exp %h", i, imem_addr, a); end
      n_chk++; if (instr_out !== 32'h0) begin n_fail++; $display("FAIL l2_wait_instr[%0d]: got %h exp 0", i, instr_out); end
      n_chk++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL l2_wait_busy[%0d]: got %b exp 1", i, fetch_busy); end
      next_cycle();
      imem_ack = 1'b1; imem_rdata = 32'hA500_0000 | a;
      #1;
      n_chk++; if (imem_addr !== a) begin n_fail++; $display("FAIL l2_ack_addr[%0d]: got %h exp %h", i, imem_addr, a); end
      n_chk++; if (instr_out !== (32'hA500_0000 | a)) begin n_fail++; $display("FAIL l2_ack_instr[%0d]: got %h exp %h", i, instr_out, 32'hA500_0000 | a); end
      n_chk++; if (PC_4_out !== a + 32'd4) begin n_fail++; $display("FAIL l2_ack_pc4[%0d]: got %h exp %h", i, PC_4_out, a + 32'd4); end
      next_cycle();
    end
    // One zero-wait fetch at 0x1C brings pc to 0x20.
    imem_ack = 1'b1; imem_rdata = 32'h1;
    #1;
    n_chk++; if (imem_addr !== 32'h1C) begin n_fail++; $display("FAIL l2_tail_addr: got %h exp 1c", imem_addr); end
    next_cycle();
    imem_ack = 1'b0;
  endtask

  // Redirect at 0x20 with no ack: drain 0x20, drop response, then fetch 0x100.
  task automatic test_redirect_outstanding();
    redirect = 1'b1; redirect_target = 32'h103;
    #1;
    n_chk++; if (instr_out !== 32'h0) begin n_fail++; $display("FAIL rd_instr: got %h exp 0", instr_out); end
    n_chk++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy: got %b exp 1", fetch_busy); end
    n_chk++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL rd_addr0: got %h exp 20", imem_addr); end
    next_cycle();
    redirect = 1'b0;
    #1;
    n_chk++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL rd_addr1: got %h exp 20", imem_addr); end
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rd_req1: got %b exp 1", imem_req); end
    next_cycle();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    n_chk++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL rd_addr2: got %h exp 20", imem_addr); end
    n_chk++; if (instr_out !== 32'h0) begin n_fail++; $display("FAIL rd_drop_instr: got %h exp 0", instr_out); end
    n_chk++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL rd_drop_busy: got %b exp 1", fetch_busy); end
    next_cycle();
    imem_ack = 1'b0;
    #1;
    n_chk++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL rd_new_addr: got %h exp 100", imem_addr); end
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rd_new_req: got %b exp 1", imem_req); end
    next_cycle();
  endtask

  // Stalled ack at 0x100 -> HOLD, then redirect+stall to 0x40.
  task automatic test_redirect_in_hold();
    stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    #1;
    next_cycle();
    imem_ack = 1'b0; redirect = 1'b1; redirect_target = 32'h40;
    #1;
    n_chk++; if (instr_out !== 32'h0) begin n_fail++; $display("FAIL rh_instr: got %h exp 0", instr_out); end
    n_chk++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL rh_busy: got %b exp 1", fetch_busy); end
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rh_req: got %b exp 0", imem_req); end
    next_cycle();
    redirect = 1'b0; stall = 1'b0;
    #1;
    n_chk++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL rh_addr: got %h exp 40", imem_addr); end
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rh_req2: got %b exp 1", imem_req); end
    n_chk++; if (instr_out !== 32'h0) begin n_fail++; $display("FAIL rh_instr2: got %h exp 0", instr_out); end
  endtask

  // Redirect coinciding with ack: new address requested the very next cycle.
  // Also exercises the 32-bit PC wrap at 0xFFFFFFFC.
  task automatic test_redirect_with_ack_and_wrap();
    imem_ack = 1'b1; imem_rdata = 32'h5555_5555; redirect = 1'b1; redirect_target = 32'hFFFF_FFFE;
    #1;
    n_chk++; if (instr_out !== 32'h0) begin n_fail++; $display("FAIL ra_instr: got %h exp 0", instr_out); end
    next_cycle();
    redirect = 1'b0; imem_rdata = 32'h0BAD_F00D;
    #1;
    n_chk++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h exp fffffffc", imem_addr); end
    n_chk++; if (PC_4_out !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h exp 0", PC_4_out); end
    n_chk++; if (instr_out !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL wrap_instr: got %h exp 0badf00d", instr_out); end
    next_cycle();
    imem_ack = 1'b0;
    #1;
    n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr: got %h exp 0", imem_addr); end
    // Redirect with ack to 0x30, then leave 0x30 outstanding.
    imem_ack = 1'b1; redirect = 1'b1; redirect_target = 32'h30;
    next_cycle();
    imem_ack = 1'b0; redirect = 1'b0;
    #1;
    n_chk++; if (imem_addr !== 32'h30) begin n_fail++; $display("FAIL ra_next_addr: got %h exp 30", imem_addr); end
    next_cycle();
  endtask

  // Reset while 0x30 is outstanding: outputs zero, restart at RESET_PC.
  task automatic test_reset_mid_wait();
    reset = 1'b1;
    #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req: got %b exp 0", imem_req); end
    n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_addr: got %h exp 0", imem_addr); end
    next_cycle();
    imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
    #1;
    n_chk++; if (instr_out !== 32'h0) begin n_fail++; $display("FAIL rm_instr: got %h exp 0", instr_out); end
    n_chk++; if (PC_4_out !== 32'h0) begin n_fail++; $display("FAIL rm_pc4: got %h exp 0", PC_4_out); end
    n_chk++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy: got %b exp 1", fetch_busy); end
    next_cycle();
    reset = 1'b0; imem_ack = 1'b0;
    #1;
    n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_first_addr: got %h exp 0", imem_addr); end
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rm_first_req: got %b exp 1", imem_req); end
    next_cycle();
    imem_ack = 1'b1; imem_rdata = 32'h2000_0000;
    #1;
    n_chk++; if (PC_4_out !== 32'h4) begin n_fail++; $display("FAIL rm_first_pc4: got %h exp 4", PC_4_out); end
    next_cycle();
    imem_ack = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    next_cycle();
    next_cycle();
    test_reset();
    test_zero_wait();
    test_stall_at_ack();
    test_latency2();
    test_redirect_outstanding();
    test_redirect_in_hold();
    test_redirect_with_ack_and_wrap();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the pipelined core, directly upstream of the IF/ID pipeline register. It owns the program counter, issues word requests to instruction memory over a req/ack handshake, and presents `instr_out` / `PC_4_out` to IF/ID. It absorbs variable memory latency, honours the hazard-unit stall, and takes branch/jump redirects. When it has no instruction to present it drives all-zero outputs, which the pipeline treats as a NOP bubble, matching the IF/ID flush value.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hazard-unit hold. IF/ID is holding, so no instruction is consumed this cycle.
- `redirect` in 1: single-cycle pulse from branch/jump resolution.
- `redirect_target` in 32: new PC; bits [1:0] are ignored and forced to 00.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: word address; held stable while `imem_req`=1 and no ack.
- `imem_ack` in 1: one-cycle pulse; may arrive in the same cycle as `imem_req` (zero-wait).
- `imem_rdata` in 32: instruction word; valid only when `imem_ack`=1.
- `instr_out` out 32: instruction to IF/ID; 0 when none is available.
- `PC_4_out` out 32: address of the presented instruction + 4; 0 when none is available.
- `fetch_busy` out 1: 1 when no instruction is available this cycle.

## Operation
- Registers: `pc` [31:0], `buf_instr` [31:0], `drain_addr` [31:0], and state ∈ {REQ, HOLD, DRAIN}.
- Reset: state=REQ, `pc`=RESET_PC, `buf_instr`=0, `drain_addr`=0.
  - While `reset`=1 all outputs are forced to 0: `imem_req`=0, `imem_addr`=0, `instr_out`=0, `PC_4_out`=0, `fetch_busy`=1.
- **Available instruction:**
  - In REQ with `imem_ack`=1 and no `redirect`: the instruction is `imem_rdata` at `pc`.
  - In HOLD with no `redirect`: the instruction is `buf_instr` at `pc`.
  - When available: `instr_out` = that instruction, `PC_4_out` = `pc`+4, `fetch_busy`=0.
  - Otherwise: `instr_out`=0, `PC_4_out`=0, `fetch_busy`=1.
- **Delivery** means an instruction is available and `stall`=0. Exactly one delivery occurs per fetched word.
- **REQ state:** `imem_req`=1, `imem_addr`=`pc`.
  - `redirect`: `pc`←target.
    - If `imem_ack`=1, the response is dropped; stay in REQ.
    - Otherwise `drain_addr`←old `pc` and go to DRAIN.
  - Else if `imem_ack` and !`stall`: deliver; `pc`←`pc`+4; stay in REQ (back-to-back fetch).
  - Else if `imem_ack` and `stall`: `buf_instr`←`imem_rdata`; go to HOLD.
  - Else (no ack): stay in REQ.
- **HOLD state:** `imem_req`=0.
  - `redirect`: `pc`←target; `buf_instr` is discarded; go to REQ.
  - Else if !`stall`: deliver `buf_instr`; `pc`←`pc`+4; go to REQ.
  - Else: stay in HOLD.
- **DRAIN state:** `imem_req`=1, `imem_addr`=`drain_addr`. This finishes the abandoned transaction without violating the handshake.
  - On `imem_ack`: the response is dropped; go to REQ.
  - A `redirect` in DRAIN updates `pc`←target and stays in DRAIN (or goes to REQ if `imem_ack` is also 1).
- **Priority:** `reset` > `redirect` > `stall`.
  - On a redirect cycle no instruction is presented; IF/ID is flushed by the hazard unit in the same cycle.
- **PC arithmetic:** 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- **Reset mid-transaction:** the outstanding request is abandoned with no drain. Instruction memory shares `reset` and must abort as well.

## Timing
- `imem_req`, `imem_addr`, `fetch_busy`, `instr_out` and `PC_4_out` are combinational from state, `pc`, `buf_instr` and the current-cycle `imem_ack`/`imem_rdata`/`redirect`. There are no combinational paths from `stall` to any output.
- Zero-wait memory: one delivery per cycle; `imem_addr` advances by 4 every cycle.
- N-cycle memory latency gives N−1 bubble cycles per instruction.
- First request is issued in the first cycle after `reset` deasserts, at address RESET_PC.
- Redirect to new-address request:
  - Same cycle the ack arrives: the new address is requested the next cycle.
  - Otherwise: the new address is requested the cycle after the drain ack.
- HOLD to delivery: in the first cycle with `stall`=0.

## Test plan
- **Zero-wait stream:** release reset (RESET_PC=0); ack every cycle with `imem_rdata`=addr|32'h2000_0000.
  - `imem_addr` must read 0, 4, 8, C on consecutive cycles.
  - `PC_4_out` must read 4, 8, C, 10, with `fetch_busy`=0 throughout.
- **2-cycle latency:** ack arrives 1 cycle after each req.
  - `instr_out`=0 and `fetch_busy`=1 on alternate cycles.
  - `imem_addr` must be held stable until each ack.
- **Stall at ack:** at `pc`=0x10, ack with 0x8C220004 while `stall`=1 for 3 cycles.
  - State is HOLD, `imem_req`=0, `instr_out`=0x8C220004 and `PC_4_out`=0x14 for all 3 cycles.
  - When `stall` drops: one delivery, then `imem_addr`=0x14.
- **Redirect with request outstanding:** at `pc`=0x20 with no ack, pulse `redirect` with target 0x103.
  - `imem_addr` must stay 0x20 until the ack arrives 2 cycles later; that response is dropped (`instr_out`=0).
  - Next `imem_addr` must be 0x100.
- **Redirect and stall in HOLD:** `stall`=1 and `redirect` (target 0x40) in the same cycle.
  - The buffered word must never be presented.
  - Next cycle: state REQ, `imem_addr`=0x40.
- **Reset mid-wait:** assert `reset` while a request is outstanding at 0x30.
  - All outputs must be 0 during reset.
  - First cycle after release: `imem_addr`=RESET_PC with no drain.
